// File: rtl/sram_responder_if.sv
// Strobe/address/data bundle between the SLC-3 control unit and its memory responder.
// Latency: n/a (wiring only); read data returns one edge after OE is sampled low.
// Backpressure: none; the requester owns timing through the active-low strobes.
// Ports: Mem_CE/OE/WE/UB/LB strobes, ADDR (MAR word address), Data_in (MDR),
//        Data_out/Data_valid (registered read return).
interface sram_responder_if #(
    parameter int DATA_W = 16
);
    logic              Mem_CE;
    logic              Mem_OE;
    logic              Mem_WE;
    logic              Mem_UB;
    logic              Mem_LB;
    logic [19:0]       ADDR;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;
    logic              Data_valid;

    modport master (
        output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
        input  Data_out, Data_valid
    );

    modport slave (
        input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_in,
        output Data_out, Data_valid
    );
endinterface

// File: rtl/sram_responder.sv
// SLC-3 memory-side responder: synchronous word array answering active-low strobes.
// Latency: read word registered at the first OE-low edge, so a two-cycle OE window latches it on edge two.
// Backpressure: none; one access per strobe-low window, held until the strobe deasserts.
// Ports: Clk, Reset (async, active-high), bus (slave modport of sram_responder_if),
//        Rd_count/Wr_count (wrapping access counters), Conflict (sticky OE&WE-low flag).
// Optional: define SRAM_BYTE_LANES_EN to let UB/LB gate the upper/lower write byte lanes.
module sram_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    sram_responder_if.slave         bus,
    output logic [15:0]             Rd_count,
    output logic [15:0]             Wr_count,
    output logic                    Conflict
);

    typedef enum logic [1:0] {IDLE, RD_DRIVE, RD_HOLD, WR_HOLD} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic [15:0]       r_rd_count;
    logic [15:0]       r_wr_count;
    logic              r_conflict;

    logic              w_sel;
    logic              w_rd;
    logic              w_wr;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    logic              w_wr_commit;

    // Write has priority over read whenever WE is low.
    assign w_sel       = ~bus.Mem_CE;
    assign w_rd        = w_sel & ~bus.Mem_OE & bus.Mem_WE;
    assign w_wr        = w_sel & ~bus.Mem_WE;
    assign w_in_range  = (bus.ADDR[19:ADDR_W] == '0);
    assign w_idx       = bus.ADDR[ADDR_W-1:0];
    // Only the first WE-low edge of a window reaches the array.
    assign w_wr_commit = ~Reset & (r_state == IDLE) & w_wr & w_in_range;

    // Array is deliberately outside the reset domain so committed data survives Reset.
    always_ff @(posedge Clk) begin
        if (w_wr_commit) begin
`ifdef SRAM_BYTE_LANES_EN
            if (!bus.Mem_UB)
                r_mem[w_idx][DATA_W-1:DATA_W/2] <= bus.Data_in[DATA_W-1:DATA_W/2];
            if (!bus.Mem_LB)
                r_mem[w_idx][DATA_W/2-1:0] <= bus.Data_in[DATA_W/2-1:0];
`else
            r_mem[w_idx] <= bus.Data_in;
`endif
        end
    end

`ifndef SRAM_BYTE_LANES_EN
    // Lane strobes have no effect when the whole word is always written.
    logic w_unused_lanes;
    assign w_unused_lanes = bus.Mem_UB & bus.Mem_LB;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_rd_count   <= '0;
            r_wr_count   <= '0;
            r_conflict   <= 1'b0;
        end else begin
            if (w_sel && !bus.Mem_OE && !bus.Mem_WE)
                r_conflict <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_wr) begin
                        r_wr_count <= r_wr_count + 16'd1;
                        r_state    <= WR_HOLD;
                    end else if (w_rd) begin
                        r_data_out   <= w_in_range ? r_mem[w_idx] : '0;
                        r_data_valid <= 1'b1;
                        r_rd_count   <= r_rd_count + 16'd1;
                        r_state      <= RD_DRIVE;
                    end
                end
                RD_DRIVE, RD_HOLD: begin
                    // Data_out is not refreshed here: one fetch per OE-low window.
                    if (w_rd) begin
                        r_state <= RD_HOLD;
                    end else begin
                        r_data_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                WR_HOLD: begin
                    if (!w_wr)
                        r_state <= IDLE;
                end
                default: begin
                    r_data_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.Data_out   = r_data_out;
    assign bus.Data_valid = r_data_valid;
    assign Rd_count       = r_rd_count;
    assign Wr_count       = r_wr_count;
    assign Conflict       = r_conflict;

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SLC-3 datapath. Answers the active-low strobes (Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB) driven by the control unit using an internal synchronous word array, address from MAR and write data from MDR. Read data is timed so that a two-cycle OE-low fetch/load window latches valid data into MDR on the second edge. Also keeps access counters and a sticky strobe-conflict flag for debug.

## Interface
- ADDR_W, 10: implemented address bits; array depth 2^ADDR_W words
- DATA_W, 16: word width
- Clk  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-high
- Mem_CE  in  1  chip enable, active-low
- Mem_OE  in  1  output enable (read), active-low
- Mem_WE  in  1  write enable, active-low
- Mem_UB  in  1  upper byte lane enable, active-low
- Mem_LB  in  1  lower byte lane enable, active-low
- ADDR  in  20  word address (MAR)
- Data_in  in  DATA_W  write data (MDR)
- Data_out  out  DATA_W  registered read data
- Data_valid  out  1  Data_out holds the current read's word
- Rd_count  out  16  completed reads, wraps
- Wr_count  out  16  completed writes, wraps
- Conflict  out  1  sticky: OE and WE sampled low together

## Operation
- Access condition sampled on each rising edge: sel = ~Mem_CE; rd = sel & ~Mem_OE & Mem_WE; wr = sel & ~Mem_WE.
- Out-of-range: ADDR[19:ADDR_W] ≠ 0 → reads load 0, writes discarded (counters still increment).
- FSM states IDLE, RD_DRIVE, RD_HOLD, WR_HOLD.
- IDLE: wr → write array, Wr_count+1, go WR_HOLD. Else rd → Data_out ← array[ADDR], Rd_count+1, go RD_DRIVE. Else stay.
- RD_DRIVE: rd still true → RD_HOLD; otherwise → IDLE.
- RD_HOLD: stay while rd true; otherwise → IDLE. No re-read while OE stays low (one read per OE-low window).
- WR_HOLD: stay while wr true; otherwise → IDLE. One write per WE-low window regardless of pulse length.
- Data_valid = 1 in RD_DRIVE and RD_HOLD only. Data_out holds last read value in other states.
- Simultaneous OE low and WE low: write wins; Conflict set at that edge, cleared only by Reset.
- Byte lanes on write: ~Mem_UB writes bits [15:8], ~Mem_LB writes [7:0]; both high → no data change, still counted. Reads ignore UB/LB, return the full word.
- Mem_CE high at any edge: treated as no access, FSM → IDLE.

## Timing
- Reset values: Data_out 0, Data_valid 0, Rd_count 0, Wr_count 0, Conflict 0, state IDLE. Array contents are not cleared.
- Read latency: OE low sampled at edge N → Data_out valid and Data_valid=1 from after edge N. Requester latches at edge N+1.
- Control-unit fetch: S_33_1 (OE low) → edge loads Data_out; S_33_2 (OE low, LD_MDR) → MDR captures correct word; S_35 (OE high) → IDLE after that edge.
- Write commits at the first edge with WE low; Data_in and ADDR are sampled only at that edge.
- Read-after-write to same address on the next access returns the new data; no bypass is needed because accesses are separated by a strobe deassert.
- Reset mid-access: immediate return to IDLE, outputs to reset values; a write already committed stays in the array.
- Counters wrap from 16'hFFFF to 0.

## Configuration
- SRAM_BYTE_LANES_EN defined: UB/LB gate the write lanes as above.
- Not defined: UB/LB ignored; every write stores the full DATA_W word.

## Test plan
- Reset then write 16'hBEEF to 0x0005 (WE low 1 cycle), then read with OE low 2 cycles → Data_out=16'hBEEF, Data_valid=1 on the second OE cycle, Rd_count=1, Wr_count=1.
- WE held low 4 cycles at 0x0010 with Data_in changing each cycle from 16'h1111 → array holds 16'h1111, Wr_count=1.
- With SRAM_BYTE_LANES_EN: memory holds 16'h1234, write 16'hABCD with UB low and LB high → read returns 16'hAB34. Without the macro, the read returns 16'hABCD.
- OE and WE low in the same cycle with Data_in=16'h00FF at 0x0001 → write occurs, Conflict=1 and stays 1 until Reset.
- Write to ADDR=20'h00400 with ADDR_W=10 → discarded, Wr_count increments. Read of 20'h00400 → Data_out=0.
- Assert Reset during RD_HOLD → Data_valid=0, Data_out=0 immediately. Previously written data is still readable afterwards.
